// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared definitions for the instruction fetch sequencer:
//               phase encodings, the IDLE instruction word, default widths
//               and the internal sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  // Default widths for the instruction word and the instruction address
  localparam int DATA_SIZE_DEFAULT = 32;
  localparam int MEM_SIZE_DEFAULT  = 10;

  // Externally visible phase encodings (2-bit phase output)
  localparam logic [1:0] PHASE_FETCH  = 2'd0;
  localparam logic [1:0] PHASE_DECODE = 2'd1;
  localparam logic [1:0] PHASE_EXEC   = 2'd2;
  localparam logic [1:0] PHASE_WB     = 2'd3;

  // Instruction word that retires the program and stops the sequencer.
  // All-ones is chosen so that small literal words (0, 1, 2, ...) are
  // never mistaken for it.
  localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;

  // Internal sequencer state. HALT has its own encoding and is folded onto
  // the WB phase value only when driving the phase output.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_t;

  // Map an internal state onto the phase value reported to the outside
  function automatic logic [1:0] state_phase(input seq_state_t s);
    logic [1:0] p;
    case (s)
      ST_FETCH:  p = PHASE_FETCH;
      ST_DECODE: p = PHASE_DECODE;
      ST_EXEC:   p = PHASE_EXEC;
      ST_WB:     p = PHASE_WB;
      ST_HALT:   p = PHASE_WB;
      default:   p = PHASE_FETCH;
    endcase
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Four-phase instruction sequencer (FETCH, DECODE, EXEC, WB)
//               driving a synchronous instruction memory. Latches the fetched
//               word into an instruction register, advances or redirects the
//               PC at the end of write-back, and stops in HALT when the IDLE
//               word retires. Reset is synchronous and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DataSize = DATA_SIZE_DEFAULT,
  parameter int MemSize  = MEM_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DataSize-1:0] instruction,
  input  logic                branch_taken,
  input  logic [MemSize-1:0]  branch_target,
  input  logic                stall,
  output logic [MemSize-1:0]  PC,
  output logic                IM_read,
  output logic                IM_write,
  output logic                IM_enable,
  output logic [DataSize-1:0] ir,
  output logic                ir_valid,
  output logic [1:0]          phase,
  output logic                halted
);

  // IDLE word resized to the configured instruction width
  localparam logic [DataSize-1:0] IDLE_INSTR = DataSize'(IDLE_WORD);

  seq_state_t          state;
  logic [MemSize-1:0]  pc_q;
  logic [DataSize-1:0] ir_q;
  logic                halted_q;
  logic                ir_is_idle;

  // The retiring instruction is compared once here and used in WB
  assign ir_is_idle = (ir_q == IDLE_INSTR);

  // Sequencer state, PC, IR and halt flag; reset dominates, HALT is sticky,
  // stall freezes every register for the cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else if (state == ST_HALT) begin
      // Only reset leaves HALT; branch and stall are ignored here
      state    <= ST_HALT;
      halted_q <= 1'b1;
    end else if (!stall) begin
      case (state)
        ST_FETCH: begin
          // IM captures PC at this edge; data is valid during DECODE
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          state <= ST_EXEC;
          ir_q  <= instruction;
        end
        ST_EXEC: begin
          state <= ST_WB;
        end
        ST_WB: begin
          if (ir_is_idle) begin
            // PC stays on the IDLE instruction
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state <= ST_FETCH;
            pc_q  <= branch_taken ? branch_target : (pc_q + MemSize'(1));
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Memory-interface and status outputs decoded from the state register;
  // everything is forced quiet while reset is held low
  always_comb begin
    IM_write  = 1'b0;
    IM_read   = 1'b0;
    IM_enable = 1'b0;
    ir_valid  = 1'b0;
    phase     = PHASE_FETCH;
    if (reset) begin
      phase     = state_phase(state);
      IM_read   = (state == ST_FETCH);
      IM_enable = (state == ST_FETCH);
      ir_valid  = (state == ST_EXEC) || (state == ST_WB);
    end
  end

  assign PC     = pc_q;
  assign ir     = ir_q;
  assign halted = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer with a
//               synchronous instruction-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset;
  logic          branch_taken;
  logic          stall;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] instruction;
  logic [AW-1:0] PC;
  logic          IM_read;
  logic          IM_write;
  logic          IM_enable;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic [1:0]    phase;
  logic          halted;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:1023];

  fetch_sequencer #(.DataSize(DW), .MemSize(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .PC           (PC),
    .IM_read      (IM_read),
    .IM_write     (IM_write),
    .IM_enable    (IM_enable),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .phase        (phase),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after a fetch
  always @(posedge clk) begin
    if (IM_enable && IM_read) instruction <= mem[PC];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Run one full instruction starting in FETCH; br/tgt applied in WB only
  task automatic do_instr(input logic [AW-1:0] pc, input logic [DW-1:0] irx,
                          input logic br, input logic [AW-1:0] tgt);
    chk("fetch_phase", phase, 0);
    chk("fetch_pc", PC, pc);
    chk("fetch_imread", IM_read, 1);
    chk("fetch_imenable", IM_enable, 1);
    chk("fetch_irvalid", ir_valid, 0);
    step();
    chk("decode_phase", phase, 1);
    chk("decode_imread", IM_read, 0);
    chk("decode_irvalid", ir_valid, 0);
    // A branch request outside WB must have no effect
    branch_taken  = 1'b1;
    branch_target = 10'h3AA;
    step();
    chk("exec_phase", phase, 2);
    chk("exec_ir", ir, irx);
    chk("exec_irvalid", ir_valid, 1);
    step();
    chk("wb_phase", phase, 3);
    chk("wb_pc", PC, pc);
    chk("wb_irvalid", ir_valid, 1);
    chk("wb_imwrite", IM_write, 0);
    branch_taken  = br;
    branch_target = tgt;
    step();
    branch_taken  = 1'b0;
    branch_target = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]      = 32'h0000_0000;
    mem[1]      = 32'h0000_0001;
    mem[2]      = 32'h0000_0002;
    mem[5]      = IDLE;
    mem[10'h3F0] = 32'h0000_03F0;
    mem[10'h3FF] = 32'hABCD_0123;

    reset         = 1'b0;
    branch_taken  = 1'b0;
    stall         = 1'b0;
    branch_target = '0;

    // Reset state
    repeat (3) step();
    chk("rst_phase", phase, 0);
    chk("rst_imread", IM_read, 0);
    chk("rst_imenable", IM_enable, 0);
    chk("rst_imwrite", IM_write, 0);
    chk("rst_irvalid", ir_valid, 0);
    chk("rst_pc", PC, 0);
    chk("rst_ir", ir, 0);
    chk("rst_halted", halted, 0);

    // Release: FETCH of PC 0 is visible immediately, PC 1 fetched in cycle 5
    reset = 1'b1;
    #1;
    do_instr(10'h000, 32'h0000_0000, 1'b0, 10'h000);
    do_instr(10'h001, 32'h0000_0001, 1'b0, 10'h000);
    // Branch in WB of PC 2, then redirect to the top word to test wrap
    do_instr(10'h002, 32'h0000_0002, 1'b1, 10'h3F0);
    do_instr(10'h3F0, 32'h0000_03F0, 1'b1, 10'h3FF);
    do_instr(10'h3FF, 32'hABCD_0123, 1'b0, 10'h000);

    // Wrapped to PC 0; stall three edges in DECODE
    chk("wrap_pc", PC, 10'h000);
    chk("wrap_imread", IM_read, 1);
    step();
    stall = 1'b1;
    chk("stall_d1_phase", phase, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_decode_phase", phase, 1);
      chk("stall_decode_ir_held", ir, 32'hABCD_0123);
      chk("stall_decode_imread", IM_read, 0);
    end
    stall = 1'b0;
    step();
    chk("post_stall_phase", phase, 2);
    chk("post_stall_ir", ir, 32'h0000_0000);
    step();
    chk("wb_stall_phase", phase, 3);
    // Stall and branch together: no redirect while stalled
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 10'h005;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("wb_stalled_phase", phase, 3);
      chk("wb_stalled_pc", PC, 10'h000);
    end
    stall = 1'b0;
    step();
    branch_taken  = 1'b0;
    branch_target = '0;

    // IDLE at PC 5 retires into HALT; branch in its WB is ignored
    do_instr(10'h005, IDLE, 1'b1, 10'h100);
    chk("halt_halted", halted, 1);
    chk("halt_phase", phase, 3);
    chk("halt_pc", PC, 10'h005);
    chk("halt_imread", IM_read, 0);
    chk("halt_irvalid", ir_valid, 0);
    for (int k = 0; k < 20; k++) begin
      branch_taken  = 1'b1;
      branch_target = 10'h100;
      stall         = k[0];
      step();
      chk("halt_hold_halted", halted, 1);
      chk("halt_hold_pc", PC, 10'h005);
      chk("halt_hold_imenable", IM_enable, 0);
    end
    branch_taken  = 1'b0;
    branch_target = '0;
    stall         = 1'b0;

    // Reset out of HALT
    reset = 1'b0;
    step();
    chk("rst_halt_pc", PC, 0);
    chk("rst_halt_ir", ir, 0);
    chk("rst_halt_halted", halted, 0);
    chk("rst_halt_phase", phase, 0);
    chk("rst_halt_imread", IM_read, 0);
    chk("rst_halt_imwrite", IM_write, 0);

    // Reset in the middle of an instruction (EXEC of PC 1)
    reset = 1'b1;
    #1;
    do_instr(10'h000, 32'h0000_0000, 1'b0, 10'h000);
    step();
    step();
    chk("mid_exec_phase", phase, 2);
    chk("mid_exec_ir", ir, 32'h0000_0001);
    chk("mid_exec_pc", PC, 10'h001);
    reset = 1'b0;
    step();
    chk("rst_exec_pc", PC, 0);
    chk("rst_exec_ir", ir, 0);
    chk("rst_exec_phase", phase, 0);
    chk("rst_exec_halted", halted, 0);
    chk("rst_exec_imenable", IM_enable, 0);
    chk("rst_exec_imwrite", IM_write, 0);
    reset = 1'b1;
    #1;
    chk("rerelease_phase", phase, 0);
    chk("rerelease_imread", IM_read, 1);
    chk("rerelease_pc", PC, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
